// File: rtl/msf_tx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// msf_tx_pkg : shared constants, types and envelope helper for the MSF/DCF77-style time-code transmitter
// Revision  : 1.0
// ---------------------------------------------------------------------------
package msf_tx_pkg;

  localparam int FRAME_BITS  = 60;
  localparam int SEC_PER_MIN = 60;
  localparam int MARKER_SEC  = 59;

  localparam int DEF_CLK_DIV          = 165;
  localparam int DEF_CARRIERS_PER_SEC = 77500;
  localparam int DEF_LOW_ZERO         = 7750;
  localparam int DEF_LOW_ONE          = 15500;

  localparam int CNT_W = 17;
  localparam int SEC_W = 6;
  localparam int LOW_W = 17;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Returns the number of carrier pulses suppressed at the start of a second.
  // The marker second carries no drop.
  function automatic logic [LOW_W-1:0] low_len(input logic             code,
                                               input logic             is_marker,
                                               input logic [LOW_W-1:0] len_zero,
                                               input logic [LOW_W-1:0] len_one);
    if (is_marker) return '0;
    return code ? len_one : len_zero;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msf_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// msf_tx_if : valid/ready channel that carries 60-bit minute frames into the transmitter
// Revision  : 1.0
// ---------------------------------------------------------------------------
interface msf_tx_if;
  import msf_tx_pkg::*;

  frame_t frame_data;
  logic   frame_valid;
  logic   frame_ready;

  modport master (output frame_data, output frame_valid, input  frame_ready);
  modport slave  (input  frame_data, input  frame_valid, output frame_ready);

endinterface
`default_nettype wire

// File: rtl/msf_tx_frame_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// msf_tx_frame_buffer : pending/active minute frames, accept handshake, minute swap and underrun detect
// Revision            : 1.0
// ---------------------------------------------------------------------------
module msf_tx_frame_buffer
  import msf_tx_pkg::*;
(
  input  logic     clk,
  input  logic     aresetn,
  msf_tx_if.slave  frame,
  input  logic     boundary,
  output frame_t   active_next,
  output logic     underrun
);

  frame_t pending;
  frame_t active;
  logic   ready;
  logic   accept;
  logic   swap;

  assign frame.frame_ready = ready;
  assign accept            = frame.frame_valid & ready;
  assign swap              = boundary & ~ready;

  // The new minute's second 0 must already see the swapped-in frame.
  assign active_next = swap ? pending : active;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pending  <= '0;
      active   <= '0;
      ready    <= 1'b1;
      underrun <= 1'b0;
    end else begin
      underrun <= boundary & ready;
      if (swap) begin
        active <= pending;
        ready  <= 1'b1;
      end
      if (accept) begin
        pending <= frame.frame_data;
        ready   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/msf_timecode_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// msf_timecode_gen : carrier prescaler, second/minute counters and amplitude envelope for the test time-code stream
// Revision         : 1.0
// ---------------------------------------------------------------------------
module msf_timecode_gen
  import msf_tx_pkg::*;
#(
  parameter int CLK_DIV          = DEF_CLK_DIV,
  parameter int CARRIERS_PER_SEC = DEF_CARRIERS_PER_SEC,
  parameter int LOW_ZERO         = DEF_LOW_ZERO,
  parameter int LOW_ONE          = DEF_LOW_ONE
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  msf_tx_if.slave          frame,
  output logic             carrier_pulse,
  output logic             msf_pulse,
  output logic             carrier_on,
  output logic [CNT_W-1:0] carrier_counter,
  output logic [SEC_W-1:0] second_counter,
  output logic             one_sec_marker,
  output logic             minute_marker,
  output logic             frame_underrun
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CARRIERS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);
  localparam logic [SEC_W-1:0] SEC_MARK = SEC_W'(MARKER_SEC);
  localparam logic [LOW_W-1:0] LEN_ZERO = LOW_W'(LOW_ZERO);
  localparam logic [LOW_W-1:0] LEN_ONE  = LOW_W'(LOW_ONE);

  logic [PRE_W-1:0] prescaler;
  logic             run;
  logic             started;
  logic             tick;
  logic [CNT_W-1:0] idx_next;
  logic [SEC_W-1:0] sec_next;
  logic             boundary;
  logic [LOW_W-1:0] low;
  logic             on_next;
  frame_t           active_next;

  // run delays the prescaler by one cycle so the first pulse lands CLK_DIV+1 cycles after enable.
  assign tick = enable & run & (prescaler == PRE_LAST);

  always_comb begin
    idx_next = carrier_counter;
    sec_next = second_counter;
    if (!started) begin
      idx_next = '0;
      sec_next = '0;
    end else if (carrier_counter == CNT_LAST) begin
      idx_next = '0;
      sec_next = (second_counter == SEC_LAST) ? '0 : second_counter + SEC_W'(1);
    end else begin
      idx_next = carrier_counter + CNT_W'(1);
    end
  end

  assign boundary = tick & (idx_next == '0) & (sec_next == '0);
  assign low      = low_len(active_next[sec_next], sec_next == SEC_MARK, LEN_ZERO, LEN_ONE);
  assign on_next  = (idx_next >= low);

  msf_tx_frame_buffer u_frame_buffer (
    .clk         (clk),
    .aresetn     (aresetn),
    .frame       (frame),
    .boundary    (boundary),
    .active_next (active_next),
    .underrun    (frame_underrun)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prescaler       <= '0;
      run             <= 1'b0;
      started         <= 1'b0;
      carrier_pulse   <= 1'b0;
      msf_pulse       <= 1'b0;
      carrier_on      <= 1'b0;
      carrier_counter <= '0;
      second_counter  <= '0;
      one_sec_marker  <= 1'b0;
      minute_marker   <= 1'b0;
    end else if (!enable) begin
      prescaler       <= '0;
      run             <= 1'b0;
      started         <= 1'b0;
      carrier_pulse   <= 1'b0;
      msf_pulse       <= 1'b0;
      carrier_on      <= 1'b0;
      carrier_counter <= '0;
      second_counter  <= '0;
      one_sec_marker  <= 1'b0;
      minute_marker   <= 1'b0;
    end else begin
      run            <= 1'b1;
      carrier_pulse  <= tick;
      msf_pulse      <= tick & on_next;
      one_sec_marker <= tick & (idx_next == '0);
      minute_marker  <= boundary;
      if (run) begin
        prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_W'(1);
      end
      if (tick) begin
        started         <= 1'b1;
        carrier_counter <= idx_next;
        second_counter  <= sec_next;
        carrier_on      <= on_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msf_timecode_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_msf_timecode_gen : randomized bench comparing the transmitter against a pulse-count reference model
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_msf_timecode_gen;
  import msf_tx_pkg::*;

  localparam int D   = 4;
  localparam int CPS = 20;
  localparam int LZ  = 2;
  localparam int LO  = 4;
  localparam int PPM = CPS * 60;

  logic clk     = 1'b0;
  logic aresetn = 1'b0;
  logic enable  = 1'b0;

  msf_tx_if fif ();

  logic             carrier_pulse, msf_pulse, carrier_on;
  logic [CNT_W-1:0] carrier_counter;
  logic [SEC_W-1:0] second_counter;
  logic             one_sec_marker, minute_marker, frame_underrun;

  msf_timecode_gen #(
    .CLK_DIV          (D),
    .CARRIERS_PER_SEC (CPS),
    .LOW_ZERO         (LZ),
    .LOW_ONE          (LO)
  ) dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .enable          (enable),
    .frame           (fif),
    .carrier_pulse   (carrier_pulse),
    .msf_pulse       (msf_pulse),
    .carrier_on      (carrier_on),
    .carrier_counter (carrier_counter),
    .second_counter  (second_counter),
    .one_sec_marker  (one_sec_marker),
    .minute_marker   (minute_marker),
    .frame_underrun  (frame_underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: everything derives from t, the count of enabled edges since the block left idle.
  int          t;
  logic [59:0] m_pend, m_act;
  bit          m_pv;
  bit          e_pulse, e_msf, e_on, e_one, e_min, e_und;
  int          e_idx, e_sec;

  function automatic int low_of(input logic [59:0] f, input int s);
    if (s == 59) return 0;
    return f[s] ? LO : LZ;
  endfunction

  task automatic reset_model();
    t = 0; m_pend = '0; m_act = '0; m_pv = 0;
    e_pulse = 0; e_msf = 0; e_on = 0; e_one = 0; e_min = 0; e_und = 0;
    e_idx = 0; e_sec = 0;
  endtask

  task automatic model_edge();
    bit old_ready;
    bit pulse;
    int n;
    if (!aresetn) begin
      reset_model();
      return;
    end
    old_ready = !m_pv;
    e_pulse = 0; e_msf = 0; e_one = 0; e_min = 0; e_und = 0;
    if (!enable) begin
      t = 0; e_idx = 0; e_sec = 0; e_on = 0;
    end else begin
      t++;
      pulse = (t > 1) && (((t - 1) % D) == 0);
      if (pulse) begin
        n     = (t - 1) / D - 1;
        e_idx = n % CPS;
        e_sec = (n / CPS) % 60;
        if (n % PPM == 0) begin
          if (m_pv) begin
            m_act = m_pend;
            m_pv  = 0;
          end else begin
            e_und = 1;
          end
        end
        e_on    = (e_idx >= low_of(m_act, e_sec));
        e_pulse = 1;
        e_msf   = e_on;
        e_one   = (e_idx == 0);
        e_min   = (e_idx == 0) && (e_sec == 0);
      end
    end
    if (fif.frame_valid && old_ready) begin
      m_pend = fif.frame_data;
      m_pv   = 1;
    end
  endtask

  function automatic bit next_is_boundary();
    int tn;
    tn = t + 1;
    if (tn <= 1 || ((tn - 1) % D) != 0) return 0;
    return (((tn - 1) / D - 1) % PPM) == 0;
  endfunction

  task automatic compare_all();
    check_val("carrier_pulse",   64'(carrier_pulse),   64'(e_pulse));
    check_val("msf_pulse",       64'(msf_pulse),       64'(e_msf));
    check_val("carrier_on",      64'(carrier_on),      64'(e_on));
    check_val("carrier_counter", 64'(carrier_counter), 64'(e_idx));
    check_val("second_counter",  64'(second_counter),  64'(e_sec));
    check_val("one_sec_marker",  64'(one_sec_marker),  64'(e_one));
    check_val("minute_marker",   64'(minute_marker),   64'(e_min));
    check_val("frame_underrun",  64'(frame_underrun),  64'(e_und));
    check_val("frame_ready",     64'(fif.frame_ready), 64'(!m_pv));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  function automatic logic [59:0] rand_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[59:0];
  endfunction

  // While a frame is pending, throw random valid/data at the closed slot; it must be ignored.
  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (m_pv) begin
        fif.frame_valid = 1'($urandom_range(0, 1));
        fif.frame_data  = rand_frame();
      end else begin
        fif.frame_valid = 1'b0;
      end
      step();
    end
    fif.frame_valid = 1'b0;
  endtask

  task automatic offer(input logic [59:0] f);
    fif.frame_valid = 1'b1;
    fif.frame_data  = f;
    step();
    fif.frame_valid = 1'b0;
  endtask

  task automatic run_to_boundary();
    int guard;
    guard = 0;
    fif.frame_valid = 1'b0;
    while (!next_is_boundary() && guard < 10000) begin
      step();
      guard++;
    end
    if (guard >= 10000) check_val("boundary_timeout", 64'(guard), 64'(0));
  endtask

  task automatic measure_first_pulse(input string tag);
    int lat;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!carrier_pulse && lat < 20);
    check_val(tag, 64'(lat), 64'(D + 1));
    check_val({tag, "_min"}, 64'(minute_marker), 64'(1));
    check_val({tag, "_sec"}, 64'(one_sec_marker), 64'(1));
  endtask

  logic [59:0] f1, f2;
  int          guard;

  initial begin
    fif.frame_valid = 1'b0;
    fif.frame_data  = '0;
    reset_model();
    repeat (3) step();
    @(negedge clk);
    aresetn = 1'b1;
    repeat (10) step();

    offer(60'h1);
    check_val("ready_after_accept", 64'(fif.frame_ready), 64'(0));

    enable = 1'b1;
    measure_first_pulse("first_pulse_lat");

    f1 = rand_frame();
    f1[59] = 1'b1;
    run($urandom_range(100, 3000));
    offer(f1);
    run_to_boundary();
    step();
    check_val("swap_no_underrun", 64'(frame_underrun), 64'(0));

    run_to_boundary();
    step();
    check_val("underrun_repeat", 64'(frame_underrun), 64'(1));
    check_val("underrun_min_marker", 64'(minute_marker), 64'(1));
    step();
    check_val("underrun_one_cycle", 64'(frame_underrun), 64'(0));

    f2 = rand_frame();
    run_to_boundary();
    fif.frame_valid = 1'b1;
    fif.frame_data  = f2;
    step();
    fif.frame_valid = 1'b0;
    fif.frame_data  = rand_frame();
    check_val("underrun_on_accept", 64'(frame_underrun), 64'(1));
    step();
    check_val("ready_low_after_boundary_accept", 64'(fif.frame_ready), 64'(0));
    run_to_boundary();
    step();
    check_val("late_frame_used", 64'(frame_underrun), 64'(0));

    run($urandom_range(50, 400));
    enable = 1'b0;
    step();
    check_val("drop_idle_counter", 64'(carrier_counter), 64'(0));
    repeat (3) step();
    enable = 1'b1;
    measure_first_pulse("reenable_lat");

    guard = 0;
    while (!(e_pulse && e_sec == 30 && e_idx == 7) && guard < 20000) begin
      step();
      guard++;
    end
    check_val("reach_sec30_idx7", 64'(second_counter), 64'(30));
    aresetn = 1'b0;
    #1;
    reset_model();
    compare_all();
    check_val("async_rst_ready", 64'(fif.frame_ready), 64'(1));
    repeat (2) step();
    @(negedge clk);
    aresetn = 1'b1;
    measure_first_pulse("restart_lat");
    check_val("restart_counter", 64'(carrier_counter), 64'(0));
    offer(rand_frame());
    run(2 * CPS * D + 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
